// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator with shadowed divide ratios.
// Optional per-channel gating when CLOCK_ENABLE_GEN_GATE_EN is defined.
module clock_enable_gen #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load_i,
`ifdef CLOCK_ENABLE_GEN_GATE_EN
    input  logic [NUM_CH-1:0]       en_i,
`endif
    output logic [NUM_CH-1:0]       ce_o,
    output logic [NUM_CH-1:0]       clk_div_o,
    output logic [NUM_CH-1:0]       pend_o
);

    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] d_q;
        logic [CNT_W-1:0] s_q;
        logic [CNT_W-1:0] c_q;
        logic             pend_q;
        logic             ce_q;
        logic             cdiv_q;
        logic             run;
        logic             slow;
        logic             wrap;
        logic             apply;
        logic [CNT_W:0]   half;
        logic [CNT_W-1:0] slice;

`ifdef CLOCK_ENABLE_GEN_GATE_EN
        assign run = en_i[g];
`else
        assign run = 1'b1;
`endif

        // Decode period position, high-phase length and ratio hand-over
        always_comb begin
            slice = div_i[g*CNT_W +: CNT_W];
            slow  = (d_q >= TWO);
            wrap  = slow ? (c_q >= (d_q - ONE)) : 1'b1;
            half  = ({1'b0, d_q} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
            // A load in the wrap cycle supersedes the old pending ratio
            apply = run && pend_q && wrap && !div_load_i[g];
        end

        // Counter, shadow/active ratios and registered outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q    <= DEF_D;
                s_q    <= DEF_D;
                c_q    <= '0;
                pend_q <= 1'b0;
                ce_q   <= 1'b0;
                cdiv_q <= 1'b0;
            end else begin
                if (div_load_i[g]) begin
                    s_q    <= slice;
                    pend_q <= 1'b1;
                end
                if (!run) begin
                    ce_q <= 1'b0;
                end else if (!slow) begin
                    c_q    <= '0;
                    ce_q   <= 1'b1;
                    cdiv_q <= 1'b1;
                end else begin
                    ce_q   <= wrap;
                    cdiv_q <= ({1'b0, c_q} < half);
                    c_q    <= wrap ? '0 : c_q + ONE;
                end
                if (apply) begin
                    d_q    <= s_q;
                    c_q    <= '0;
                    pend_q <= 1'b0;
                end
            end
        end

        assign ce_o[g]      = ce_q;
        assign clk_div_o[g] = cdiv_q;
        assign pend_o[g]    = pend_q;
    end

endmodule
